// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default operand widths, the divider state
// encoding and a helper for sizing counters.
package arith_pkg;

    localparam int DW_DEF = 8;   // dividend / quotient width
    localparam int VW_DEF = 4;   // divisor / remainder width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Width of a down-counter that must hold values 0..w-1 (never below 1 bit).
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider. The master issues
// start with operands; the slave (the divider) returns results and status.
interface seq_divider_if import arith_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) ();
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep or restore.
module div_step import arith_pkg::*; #(
    parameter int VW = VW_DEF
) (
    input  logic [VW-1:0] rem,
    input  logic          nbit,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] new_rem,
    output logic          q_bit
);
    logic [VW:0]   trial;
    logic [VW-1:0] diff;

    assign trial = {rem, nbit};
    assign q_bit = (trial >= {1'b0, divisor});
    // rem < divisor on entry, so a successful difference always fits VW bits
    // and the low VW bits of the subtraction are exact.
    assign diff    = trial[VW-1:0] - divisor;
    assign new_rem = q_bit ? diff : trial[VW-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Zero divisor short-circuits to DONE with all-ones quotient and a flag.
module seq_divider import arith_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CW = cnt_w(DW);

    div_state_e    state;
    logic [DW-1:0] dvd;      // shifts left; quotient bits enter at the LSB
    logic [VW-1:0] dsr;
    logic [VW-1:0] rem;
    logic [CW-1:0] cnt;
    logic [DW-1:0] q_r;
    logic [VW-1:0] r_r;
    logic          busy_r;
    logic          done_r;
    logic          dbz_r;

    logic [VW-1:0] step_rem;
    logic          step_q;

    div_step #(.VW(VW)) u_step (
        .rem     (rem),
        .nbit    (dvd[DW-1]),
        .divisor (dsr),
        .new_rem (step_rem),
        .q_bit   (step_q)
    );

    assign bus.quotient    = q_r;
    assign bus.remainder   = r_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

    // Control FSM and datapath; results only change on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            cnt    <= '0;
            q_r    <= '0;
            r_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd    <= bus.dividend;
                        dsr    <= bus.divisor;
                        rem    <= '0;
                        cnt    <= CW'(DW - 1);
                        busy_r <= 1'b1;
                        dbz_r  <= 1'b0;
                        if (bus.divisor == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            dbz_r  <= 1'b1;
                            q_r    <= '1;
                            r_r    <= bus.dividend[VW-1:0];
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= step_rem;
                    dvd <= {dvd[DW-2:0], step_q};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        q_r    <= {dvd[DW-2:0], step_q};
                        r_r    <= step_rem;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic model.
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // count every done pulse seen, to prove single/absent pulses
    always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // called just after a negedge; returns just after the negedge following acceptance
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // lat counts accepting-edge-relative cycles; bounded
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [7:0] a, input logic [3:0] b);
        int lat, elat;
        logic [7:0] eq;
        logic [3:0] er;
        logic ez;
        if (b != 0) begin
            eq = a / {4'b0, b}; er = 4'(a % {4'b0, b}); elat = DW + 1; ez = 1'b0;
        end else begin
            eq = 8'hFF; er = a[3:0]; elat = 1; ez = 1'b1;
        end
        launch(a, b);
        wait_done(1, lat);
        chk({tag, "/lat"}, lat, elat);
        chk({tag, "/q"}, bus.quotient, eq);
        chk({tag, "/r"}, bus.remainder, er);
        chk({tag, "/dbz"}, bus.div_by_zero, ez);
        if (b != 0) begin
            chk({tag, "/inv"}, 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
            chk({tag, "/rlt"}, 32'(bus.remainder < b), 1);
        end
        @(negedge clk);
        chk({tag, "/done1cyc"}, bus.done, 0);
        chk({tag, "/idle"}, bus.busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0;
        int order[4096];
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst/q", bus.quotient, 0);
        chk("rst/r", bus.remainder, 0);
        chk("rst/busy", bus.busy, 0);
        chk("rst/done", bus.done, 0);
        chk("rst/dbz", bus.div_by_zero, 0);

        // first start taken at the first edge after release
        rst_n = 1'b1;
        op_check("100/7", 8'd100, 4'd7);
        op_check("255/15", 8'd255, 4'd15);
        op_check("3/9", 8'd3, 4'd9);
        op_check("A5/0", 8'hA5, 4'd0);

        // second start mid-run is ignored; old results held during run
        d0 = done_cnt;
        launch(8'd100, 4'd7);
        repeat (2) @(negedge clk);
        chk("hold/q", bus.quotient, 8'hFF);
        chk("hold/r", bus.remainder, 4'h5);
        chk("hold/dbz", bus.div_by_zero, 0);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(4, lat);
        chk("ign/lat", lat, DW + 1);
        chk("ign/q", bus.quotient, 14);
        chk("ign/r", bus.remainder, 2);
        repeat (15) @(negedge clk);
        chk("ign/ndone", done_cnt - d0, 1);
        chk("ign/busy", bus.busy, 0);

        // start held through the done cycle is taken only once back in IDLE
        launch(8'd77, 4'd8);
        wait_done(1, lat);
        chk("b2b/q0", bus.quotient, 9);
        chk("b2b/r0", bus.remainder, 5);
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
        @(posedge clk);
        @(negedge clk);
        chk("b2b/notake", bus.busy, 0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b/take", bus.busy, 1);
        wait_done(1, lat);
        chk("b2b/lat", lat, DW + 1);
        chk("b2b/q", bus.quotient, 10);
        chk("b2b/r", bus.remainder, 0);
        @(negedge clk);

        // asynchronous reset in the fourth RUN cycle discards the operation
        launch(8'd100, 4'd7);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst/q", bus.quotient, 0);
        chk("arst/r", bus.remainder, 0);
        chk("arst/busy", bus.busy, 0);
        chk("arst/done", bus.done, 0);
        chk("arst/dbz", bus.div_by_zero, 0);
        repeat (12) @(negedge clk);
        chk("arst/nodone", done_cnt - d0, 0);
        rst_n = 1'b1;
        op_check("post", 8'd100, 4'd7);

        // every operand pair, in random order
        for (int i = 0; i < 4096; i++) order[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 4096; i++)
            op_check("sw", 8'(order[i] >> 4), 4'(order[i] & 15));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DW, default 8, dividend/quotient width.
REQ-002 SHALL have parameter VW, default 4, divisor/remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port dividend  input  DW  unsigned numerator, captured when start is accepted.
REQ-007 SHALL have port divisor  input  VW  unsigned denominator, captured when start is accepted.
REQ-008 SHALL have port quotient  output  DW  registered result.
REQ-009 SHALL have port remainder  output  VW  registered result.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-012 SHALL have port div_by_zero  output  1  registered flag, valid with done, held until the next accepted start.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE; on acceptance it SHALL capture the operands, clear the partial remainder, set the iteration counter to DW-1, clear div_by_zero, and enter RUN, or enter DONE if divisor==0.
REQ-015 SHALL ignore start while busy, with no effect on state or operands.
REQ-016 SHALL, in RUN, perform one restoring step per cycle, MSB first: shift {rem, dividend_msb} into a VW+1-bit trial, subtract divisor, and on no borrow keep the difference and set the quotient bit to 1; otherwise it SHALL restore and set the bit to 0.
REQ-017 SHALL leave RUN for DONE after exactly DW steps, when the counter reaches 0.
REQ-018 SHALL give a nonzero divisor a latency of DW+1 cycles from the accepting edge to the edge at which done is first visible; at default parameters that is 9.
REQ-019 SHALL, for a zero divisor, set quotient to all ones, set remainder to dividend[VW-1:0], assert div_by_zero, and raise done 1 cycle after acceptance.
REQ-020 SHALL assert done for exactly one cycle (the DONE state) and then return to IDLE.
REQ-021 SHALL update quotient and remainder only on entry to DONE, holding them stable at all other times, including during a subsequent RUN.
REQ-022 SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.
REQ-023 SHALL accept start asserted in the cycle done is high only after the return to IDLE; start SHALL be accepted in IDLE no earlier than the cycle after done.
REQ-024 SHALL return to IDLE within the same cycle if rst_n is asserted mid-RUN, discarding the operation with no done pulse.

Reset
REQ-025 SHALL, while rst_n is low, force state IDLE and quotient, remainder, busy, done, div_by_zero, the counter and internal operand registers to 0, asynchronously.
REQ-026 SHALL take its first accepted start at the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take DW/VW defaults and the state enum (IDLE, RUN, DONE) from the shared package arith_pkg.
REQ-028 SHALL place the single-step trial subtract/restore in one combinational sub-module div_step, with inputs rem, next bit and divisor and outputs new rem and q_bit.
REQ-029 SHALL use a counter width of clog2(DW).

Verification
REQ-030 SHALL cover: dividend=100, divisor=7, start -> 9 cycles later done=1, quotient=14, remainder=2, div_by_zero=0.
REQ-031 SHALL cover: dividend=255, divisor=15 -> quotient=17, remainder=0; and dividend=3, divisor=9 -> quotient=0, remainder=3.
REQ-032 SHALL cover: dividend=0xA5, divisor=0 -> done 1 cycle after start, quotient=0xFF, remainder=0x5, div_by_zero=1.
REQ-033 SHALL cover: start pulsed again 3 cycles into RUN with different operands -> ignored; results match the first operands; done occurs once.
REQ-034 SHALL cover: rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done; a new start after release -> correct result.
REQ-035 SHALL cover: random sweep of all 256x16 operand pairs -> each satisfies REQ-022 and the latency of REQ-018.
